// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART core with TX/RX byte FIFOs behind a CTRL/TXDATA/RXDATA/STATUS register map
// Parity generation/checking is compiled in only when UART_PARITY_EN is defined.
module uart_fifo_core #(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8,
   parameter int DIV_W    = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ren,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx_o,
   input  logic        rx_i,
   output logic        intr_tx,
   output logic        intr_rx,
   output logic        intr_err
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TCW = TAW + 1;
   localparam int RCW = RAW + 1;
   localparam logic [31:0] DIV_MASK = 32'(((64'd1 << DIV_W) - 64'd1) << 16);
`ifdef UART_PARITY_EN
   localparam logic [31:0] CTRL_MASK = DIV_MASK | 32'h0000_03FF;
`else
   localparam logic [31:0] CTRL_MASK = DIV_MASK | 32'h0000_03F3;
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [31:0]      r_ctrl;
   logic             w_tx_en, w_rx_en;
   logic [5:0]       w_thresh;
   logic [DIV_W-1:0] w_div, w_half;
   logic             w_wr_ctrl, w_wr_tx, w_wr_stat, w_rd_rx;

   assign w_tx_en   = r_ctrl[0];
   assign w_rx_en   = r_ctrl[1];
   assign w_thresh  = (r_ctrl[9:4] == 6'd0) ? 6'd1 : r_ctrl[9:4];
   assign w_div     = (r_ctrl[16 +: DIV_W] < DIV_W'(2)) ? DIV_W'(2) : r_ctrl[16 +: DIV_W];
   assign w_half    = w_div >> 1;
   assign w_wr_ctrl = we && (addr == 4'h0);
   assign w_wr_tx   = we && (addr == 4'h4);
   assign w_wr_stat = we && (addr == 4'hC);
   assign w_rd_rx   = ren && (addr == 4'h8);

`ifdef UART_PARITY_EN
   logic w_par_en, w_par_odd;
   assign w_par_en  = r_ctrl[2];
   assign w_par_odd = r_ctrl[3];
`endif

   // ---------------- TX FIFO ----------------
   logic [7:0]     r_tx_mem [TX_DEPTH];
   logic [TAW-1:0] r_tx_wptr, r_tx_rptr;
   logic [TCW-1:0] r_tx_cnt;
   logic           w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_ovf_set;

   assign w_tx_full    = (r_tx_cnt == TCW'(TX_DEPTH));
   assign w_tx_empty   = (r_tx_cnt == '0);
   assign w_tx_push    = w_wr_tx && (!w_tx_full || w_tx_pop);
   assign w_tx_ovf_set = w_wr_tx && !w_tx_push;

   always_ff @(posedge clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= wdata[7:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tx_wptr <= '0;
         r_tx_rptr <= '0;
         r_tx_cnt  <= '0;
      end else begin
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
            2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
            default: r_tx_cnt <= r_tx_cnt;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   state_t           r_tx_state, w_tx_next;
   logic [DIV_W-1:0] r_tx_bcnt;
   logic [2:0]       r_tx_bit;
   logic [7:0]       r_tx_shift;
   logic             w_tx_tick;
`ifdef UART_PARITY_EN
   logic             r_tx_pen, r_tx_par;
`endif

   // >= rather than == keeps the bit timer sane if div shrinks mid-bit
   assign w_tx_tick = (r_tx_bcnt >= w_div - 1'b1);

   always_comb begin
      w_tx_next = r_tx_state;
      w_tx_pop  = 1'b0;
      case (r_tx_state)
         S_IDLE: begin
            if (w_tx_en && !w_tx_empty) begin
               w_tx_pop  = 1'b1;
               w_tx_next = S_START;
            end
         end
         S_START: if (w_tx_tick) w_tx_next = S_DATA;
         S_DATA: begin
            if (w_tx_tick && (r_tx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
               w_tx_next = r_tx_pen ? S_PARITY : S_STOP;
`else
               w_tx_next = S_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: if (w_tx_tick) w_tx_next = S_STOP;
`endif
         S_STOP: begin
            if (w_tx_tick) begin
               if (w_tx_en && !w_tx_empty) begin
                  w_tx_pop  = 1'b1;
                  w_tx_next = S_START;
               end else begin
                  w_tx_next = S_IDLE;
               end
            end
         end
         default: w_tx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tx_state <= S_IDLE;
         r_tx_bcnt  <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
`ifdef UART_PARITY_EN
         r_tx_pen   <= 1'b0;
         r_tx_par   <= 1'b0;
`endif
      end else begin
         r_tx_state <= w_tx_next;
         if ((r_tx_state == S_IDLE) || w_tx_tick) r_tx_bcnt <= '0;
         else                                     r_tx_bcnt <= r_tx_bcnt + 1'b1;
         if (w_tx_pop) begin
            r_tx_shift <= r_tx_mem[r_tx_rptr];
            r_tx_bit   <= '0;
`ifdef UART_PARITY_EN
            r_tx_pen   <= w_par_en;
            r_tx_par   <= (^r_tx_mem[r_tx_rptr]) ^ w_par_odd;
`endif
         end else if ((r_tx_state == S_DATA) && w_tx_tick) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
         end
      end
   end

   always_comb begin
      case (r_tx_state)
         S_START:  tx_o = 1'b0;
         S_DATA:   tx_o = r_tx_shift[0];
`ifdef UART_PARITY_EN
         S_PARITY: tx_o = r_tx_par;
`endif
         default:  tx_o = 1'b1;
      endcase
   end

   // ---------------- RX FSM ----------------
   logic             r_rx_s1, r_rx_s2, r_rx_prev;
   state_t           r_rx_state, w_rx_next;
   logic [DIV_W-1:0] r_rx_bcnt;
   logic [2:0]       r_rx_bit;
   logic [7:0]       r_rx_shift;
   logic             w_rx_fall, w_rx_tick, w_rx_done, w_rx_good, w_ferr_set;
`ifdef UART_PARITY_EN
   logic             r_rx_pbad, w_perr_set;
`endif

   assign w_rx_fall  = r_rx_prev && !r_rx_s2;
   assign w_rx_tick  = (r_rx_state == S_START) ? (r_rx_bcnt >= w_half - 1'b1)
                                               : (r_rx_bcnt >= w_div - 1'b1);
   assign w_rx_done  = (r_rx_state == S_STOP) && w_rx_tick;
   assign w_ferr_set = w_rx_done && !r_rx_s2;
`ifdef UART_PARITY_EN
   assign w_perr_set = w_rx_done && r_rx_s2 && r_rx_pbad;
   assign w_rx_good  = w_rx_done && r_rx_s2 && !r_rx_pbad;
`else
   assign w_rx_good  = w_rx_done && r_rx_s2;
`endif

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         S_IDLE:  if (w_rx_en && w_rx_fall) w_rx_next = S_START;
         S_START: if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
         S_DATA: begin
            if (w_rx_tick && (r_rx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
               w_rx_next = w_par_en ? S_PARITY : S_STOP;
`else
               w_rx_next = S_STOP;
`endif
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: if (w_rx_tick) w_rx_next = S_STOP;
`endif
         S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
         default: w_rx_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rx_s1    <= 1'b1;
         r_rx_s2    <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= S_IDLE;
         r_rx_bcnt  <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
`ifdef UART_PARITY_EN
         r_rx_pbad  <= 1'b0;
`endif
      end else begin
         r_rx_s1    <= rx_i;
         r_rx_s2    <= r_rx_s1;
         r_rx_prev  <= r_rx_s2;
         r_rx_state <= w_rx_next;
         if ((r_rx_state == S_IDLE) || w_rx_tick) r_rx_bcnt <= '0;
         else                                     r_rx_bcnt <= r_rx_bcnt + 1'b1;
         if (r_rx_state == S_START) r_rx_bit <= '0;
         if ((r_rx_state == S_DATA) && w_rx_tick) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
         end
`ifdef UART_PARITY_EN
         if (r_rx_state == S_START) r_rx_pbad <= 1'b0;
         else if ((r_rx_state == S_PARITY) && w_rx_tick)
            r_rx_pbad <= ((^r_rx_shift) ^ r_rx_s2) != w_par_odd;
`endif
      end
   end

   // ---------------- RX FIFO ----------------
   logic [7:0]     r_rx_mem [RX_DEPTH];
   logic [RAW-1:0] r_rx_wptr, r_rx_rptr;
   logic [RCW-1:0] r_rx_cnt;
   logic           w_rx_full, w_rx_empty, w_rx_push, w_rx_pop, w_rxovf_set;

   assign w_rx_full   = (r_rx_cnt == RCW'(RX_DEPTH));
   assign w_rx_empty  = (r_rx_cnt == '0);
   assign w_rx_pop    = w_rd_rx && !w_rx_empty;
   assign w_rx_push   = w_rx_good && (!w_rx_full || w_rx_pop);
   assign w_rxovf_set = w_rx_good && !w_rx_push;

   always_ff @(posedge clk_i) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= r_rx_shift;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rx_wptr <= '0;
         r_rx_rptr <= '0;
         r_rx_cnt  <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
            2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
            default: r_rx_cnt <= r_rx_cnt;
         endcase
      end
   end

   // ---------------- registers, sticky status ----------------
   logic r_tx_ovf, r_rx_ovf, r_frame_err, w_par_err;
`ifdef UART_PARITY_EN
   logic r_par_err;
   assign w_par_err = r_par_err;
`else
   assign w_par_err = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ctrl      <= '0;
         r_tx_ovf    <= 1'b0;
         r_rx_ovf    <= 1'b0;
         r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_par_err   <= 1'b0;
`endif
      end else begin
         if (w_wr_ctrl) r_ctrl <= wdata & CTRL_MASK;
         r_tx_ovf    <= w_tx_ovf_set | (r_tx_ovf    & ~(w_wr_stat & wdata[4]));
         r_rx_ovf    <= w_rxovf_set  | (r_rx_ovf    & ~(w_wr_stat & wdata[5]));
         r_frame_err <= w_ferr_set   | (r_frame_err & ~(w_wr_stat & wdata[6]));
`ifdef UART_PARITY_EN
         r_par_err   <= w_perr_set   | (r_par_err   & ~(w_wr_stat & wdata[7]));
`endif
      end
   end

   logic [7:0]  w_tx_lvl, w_rx_lvl;
   logic [31:0] w_status;

   assign w_tx_lvl = {{(8-TCW){1'b0}}, r_tx_cnt};
   assign w_rx_lvl = {{(8-RCW){1'b0}}, r_rx_cnt};
   assign w_status = {8'h00, w_rx_lvl, w_tx_lvl, w_par_err, r_frame_err, r_rx_ovf, r_tx_ovf,
                      w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

   // rdata is forced to zero while reset is held, not just once registers clear
   always_comb begin
      rdata = '0;
      if (!rst_i) begin
         case (addr)
            4'h0:    rdata = r_ctrl;
            4'h8:    rdata = w_rx_empty ? 32'h0 : {24'h0, r_rx_mem[r_rx_rptr]};
            4'hC:    rdata = w_status;
            default: rdata = '0;
         endcase
      end
   end

   assign intr_tx  = w_tx_empty && (r_tx_state == S_IDLE);
   assign intr_rx  = (w_rx_lvl >= {2'b00, w_thresh});
   assign intr_err = r_tx_ovf | r_rx_ovf | r_frame_err | w_par_err;

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - randomized self-checking bench for uart_fifo_core against a queue-based model
module tb_uart_fifo_core;
   logic        clk, rst, ren, we, tx_o, rx_i, intr_tx, intr_rx, intr_err;
   logic [3:0]  addr;
   logic [31:0] wdata, rdata, d;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   logic [7:0] m_txq[$];
   logic [7:0] m_rxq[$];
   logic       m_tx_ovf = 0, m_rx_ovf = 0, m_ferr = 0, m_perr = 0;
   int         m_thresh = 1;

   uart_fifo_core dut (
      .clk_i(clk), .rst_i(rst), .ren(ren), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .tx_o(tx_o), .rx_i(rx_i), .intr_tx(intr_tx), .intr_rx(intr_rx),
      .intr_err(intr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s        = '0;
      s[0]     = (m_txq.size() == 8);
      s[1]     = (m_txq.size() == 0);
      s[2]     = (m_rxq.size() == 8);
      s[3]     = (m_rxq.size() == 0);
      s[4]     = m_tx_ovf;
      s[5]     = m_rx_ovf;
      s[6]     = m_ferr;
      s[7]     = m_perr;
      s[15:8]  = 8'(m_txq.size());
      s[23:16] = 8'(m_rxq.size());
      return s;
   endfunction

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      @(negedge clk);
      we = 1'b1; addr = a; wdata = v;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] v);
      @(negedge clk);
      ren = 1'b1; addr = a;
      #1 v = rdata;
      @(negedge clk);
      ren = 1'b0;
   endtask

   task automatic tx_push(input logic [7:0] b);
      if (m_txq.size() < 8) m_txq.push_back(b);
      else                  m_tx_ovf = 1'b1;
      wr(4'h4, {24'h0, b});
   endtask

   // Expected line: start 0, data LSB first, stop 1, each held div cycles.
   task automatic tx_expect(input int div, input int nframes);
      logic [7:0] b;
      logic [9:0] fr;
      for (int f = 0; f < nframes; f++) begin
         b  = m_txq.pop_front();
         fr = {1'b1, b, 1'b0};
         for (int k = 0; k < 10 * div; k++) begin
            @(negedge clk);
            check($sformatf("tx_o f%0d c%0d", f, k), 32'(tx_o), 32'(fr[k / div]));
            if (f == 0 && k == 0) check("intr_tx busy", 32'(intr_tx), 32'd0);
         end
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input int div, input logic stop_v,
                          input logic use_par, input logic par_v);
      @(negedge clk);
      rx_i = 1'b0;
      repeat (div) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (div) @(negedge clk);
      end
      if (use_par) begin
         rx_i = par_v;
         repeat (div) @(negedge clk);
      end
      rx_i = stop_v;
      repeat (div) @(negedge clk);
      rx_i = 1'b1;
      repeat (div + 2) @(negedge clk);
   endtask

   task automatic rx_model(input logic [7:0] b, input logic stop_v);
      if (!stop_v)                 m_ferr = 1'b1;
      else if (m_rxq.size() < 8)   m_rxq.push_back(b);
      else                         m_rx_ovf = 1'b1;
   endtask

   initial begin
      logic [7:0] b;
      int         div;
      rst = 1'b1; ren = 1'b0; we = 1'b0; addr = 4'hC; wdata = '0; rx_i = 1'b1;

      // reset state
      @(negedge clk);
      check("rst tx_o", 32'(tx_o), 32'd1);
      check("rst rdata", rdata, 32'd0);
      check("rst intr_tx", 32'(intr_tx), 32'd1);
      check("rst intr_rx", 32'(intr_rx), 32'd0);
      check("rst intr_err", 32'(intr_err), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rd(4'hC, d); check("rst STATUS", d, 32'h0000_000A);
      rd(4'h0, d); check("rst CTRL", d, 32'h0);

      // CTRL readback; parity bits only stick in the parity build
      wr(4'h0, 32'h0004_03FC);
      rd(4'h0, d);
`ifdef UART_PARITY_EN
      check("CTRL readback", d, 32'h0004_03FC);
`else
      check("CTRL readback", d, 32'h0004_03F0);
`endif

      // 0xA5 at div 4
      wr(4'h0, 32'h0004_0000);
      tx_push(8'hA5);
      wr(4'h0, 32'h0004_0001);
      tx_expect(4, 1);
      @(negedge clk);
      check("intr_tx idle", 32'(intr_tx), 32'd1);

      // overflow with 9 random writes, clear, then drain at div=1 (treated as 2)
      wr(4'h0, 32'h0000_0000);
      for (int i = 0; i < 9; i++) tx_push(8'($urandom_range(0, 255)));
      rd(4'hC, d); check("tx full STATUS", d, exp_status());
      check("tx ovf intr_err", 32'(intr_err), 32'd1);
      wr(4'hC, 32'h10); m_tx_ovf = 1'b0;
      rd(4'hC, d); check("tx ovf clear STATUS", d, exp_status());
      check("tx ovf clear intr_err", 32'(intr_err), 32'd0);
      wr(4'h0, 32'h0001_0001);
      tx_expect(2, 8);
      @(negedge clk);
      check("tx drained intr_tx", 32'(intr_tx), 32'd1);
      rd(4'hC, d); check("tx drained STATUS", d, exp_status());

      // push while full in the same cycle the FSM pops
      wr(4'h0, 32'h0002_0000);
      for (int i = 0; i < 8; i++) tx_push(8'($urandom_range(0, 255)));
      b = 8'($urandom_range(0, 255));
      @(negedge clk); we = 1'b1; addr = 4'h0; wdata = 32'h0002_0001;
      @(negedge clk); addr = 4'h4; wdata = {24'h0, b};
      @(negedge clk); we = 1'b0;
      void'(m_txq.pop_front());
      m_txq.push_back(b);
      rd(4'hC, d); check("tx full push+pop STATUS", d, exp_status());
      repeat (9 * 20 + 10) @(negedge clk);
      m_txq.delete();
      rd(4'hC, d); check("tx full push+pop drained", d, exp_status());

      // clearing tx_en mid-frame finishes that frame, then idles
      wr(4'h0, 32'h0003_0000);
      tx_push(8'($urandom_range(0, 255)));
      tx_push(8'($urandom_range(0, 255)));
      wr(4'h0, 32'h0003_0001);
      fork
         begin
            tx_expect(3, 1);
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               check("tx_o held idle", 32'(tx_o), 32'd1);
            end
         end
         begin
            repeat (5) @(negedge clk);
            wr(4'h0, 32'h0003_0000);
         end
      join
      rd(4'hC, d); check("tx_en off STATUS", d, exp_status());
      check("tx_en off intr_tx", 32'(intr_tx), 32'd0);
      wr(4'h0, 32'h0003_0001);
      tx_expect(3, 1);

      // RX 0x3C at div 8
      wr(4'h0, 32'h0008_0002);
      send_rx(8'h3C, 8, 1'b1, 1'b0, 1'b0); rx_model(8'h3C, 1'b1);
      rd(4'hC, d); check("rx one STATUS", d, exp_status());
      check("rx one intr_rx", 32'(intr_rx), 32'd1);
      rd(4'h8, d); check("rx 0x3C", d, {24'h0, m_rxq.pop_front()});
      rd(4'hC, d); check("rx popped STATUS", d, exp_status());
      rd(4'h8, d); check("rx empty read", d, 32'h0);
      rd(4'hC, d); check("rx empty no pop", d, exp_status());

      // random RX with frame errors and overflow, threshold 3
      div = $urandom_range(4, 10);
      m_thresh = 3;
      wr(4'h0, (32'(div) << 16) | 32'h0000_0032);
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom_range(0, 255));
         send_rx(b, div, (i % 4) != 3, 1'b0, 1'b0);
         rx_model(b, (i % 4) != 3);
         rd(4'hC, d); check($sformatf("rx rand %0d STATUS", i), d, exp_status());
         check($sformatf("rx rand %0d intr_rx", i), 32'(intr_rx),
               32'(m_rxq.size() >= m_thresh));
      end
      check("rx err intr_err", 32'(intr_err), 32'd1);
      for (int i = 0; i < 8; i++) begin
         rd(4'h8, d); check($sformatf("rx drain %0d", i), d, {24'h0, m_rxq.pop_front()});
      end
      wr(4'hC, 32'hF0);
      m_tx_ovf = 0; m_rx_ovf = 0; m_ferr = 0; m_perr = 0;
      rd(4'hC, d); check("rx cleared STATUS", d, exp_status());
      check("rx cleared intr_err", 32'(intr_err), 32'd0);

      // short low glitch must be a false start
      wr(4'h0, 32'h0008_0002);
      @(negedge clk); rx_i = 1'b0;
      repeat (2) @(negedge clk); rx_i = 1'b1;
      repeat (24) @(negedge clk);
      rd(4'hC, d); check("glitch STATUS", d, exp_status());
      b = 8'($urandom_range(0, 255));
      send_rx(b, 8, 1'b1, 1'b0, 1'b0); rx_model(b, 1'b1);
      rd(4'h8, d); check("after glitch byte", d, {24'h0, m_rxq.pop_front()});

`ifdef UART_PARITY_EN
      // odd parity: 0x01 needs parity bit 0, so the even-parity bit 1 is wrong
      wr(4'h0, 32'h0008_000E);
      send_rx(8'h01, 8, 1'b1, 1'b1, 1'b1); m_perr = 1'b1;
      rd(4'hC, d); check("par_err STATUS", d, exp_status());
      check("par_err intr_err", 32'(intr_err), 32'd1);
      wr(4'hC, 32'h80); m_perr = 1'b0;
      send_rx(8'h01, 8, 1'b1, 1'b1, 1'b0); m_rxq.push_back(8'h01);
      rd(4'h8, d); check("par good byte", d, {24'h0, m_rxq.pop_front()});
`endif

      // reset during a TX frame and an RX frame
      wr(4'h4, 32'hFF);
      wr(4'h0, 32'h0004_0003);
      addr = 4'hC;
      fork
         send_rx(8'h55, 4, 1'b1, 1'b0, 1'b0);
         begin
            repeat (2) @(negedge clk);
            check("pre-rst tx_o", 32'(tx_o), 32'd0);
            #2 rst = 1'b1;
            #1;
            check("async rst tx_o", 32'(tx_o), 32'd1);
            check("async rst rdata", rdata, 32'd0);
            check("async rst intr_tx", 32'(intr_tx), 32'd1);
            check("async rst intr_rx", 32'(intr_rx), 32'd0);
            check("async rst intr_err", 32'(intr_err), 32'd0);
         end
      join
      @(negedge clk); rst = 1'b0;
      m_txq.delete(); m_rxq.delete();
      rd(4'hC, d); check("post-rst STATUS", d, 32'h0000_000A);
      rd(4'h0, d); check("post-rst CTRL", d, 32'h0);
      repeat (40) @(negedge clk);
      rd(4'hC, d); check("post-rst no partial", d, 32'h0000_000A);
      check("post-rst tx_o", 32'(tx_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
